// File: rtl/hazard_pkg.sv
// Shared types, constants and helpers for the ID-stage hazard control unit.
package hazard_pkg;

    // Load-use stall sequencer states
    typedef enum logic {
        IDLE     = 1'b0,
        LU_STALL = 1'b1
    } hz_state_e;

    // Encoding reported on hazard_type_o
    localparam logic [1:0] HZ_NONE    = 2'd0;
    localparam logic [1:0] HZ_LOADUSE = 2'd1;
    localparam logic [1:0] HZ_BRANCH  = 2'd2;
    localparam logic [1:0] HZ_MEMFRZ  = 2'd3;

    // Widest register address the match helper accepts; callers zero-extend
    localparam int MAX_REG_AW = 16;

    // A source depends on a destination only if it is actually read, the
    // numbers agree, and the destination is not the hard-wired zero register.
    function automatic logic reg_match(
        input logic                  use_src,
        input logic [MAX_REG_AW-1:0] src,
        input logic [MAX_REG_AW-1:0] dst
    );
        return use_src && (src == dst) && (dst != {MAX_REG_AW{1'b0}});
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments when inc_i is high, sticks at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_r;

    // Count qualifying cycles, holding at the maximum instead of wrapping
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_r <= {W{1'b0}};
        end else if (inc_i && (cnt_r != {W{1'b1}})) begin
            cnt_r <= cnt_r + W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt_o = cnt_r;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// ID-stage hazard control: load-use stalls (multi-cycle), branch-in-ID operand
// stalls, data-cache freeze, and a saturating stall-cycle statistic.
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW          = 5,
    parameter int LOAD_USE_CYCLES = 1,
    parameter int BRANCH_IN_ID    = 1,
    parameter int STAT_W          = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [REG_AW-1:0] ifid_rs_i,
    input  logic [REG_AW-1:0] ifid_rt_i,
    input  logic              ifid_use_rs_i,
    input  logic              ifid_use_rt_i,
    input  logic              ifid_branch_i,
    input  logic              idex_mem_read_i,
    input  logic              idex_reg_write_i,
    input  logic [REG_AW-1:0] idex_rd_i,
    input  logic              exmem_mem_read_i,
    input  logic [REG_AW-1:0] exmem_rd_i,
    input  logic              dmem_stall_i,
    output logic              pc_write_o,
    output logic              ifid_write_o,
    output logic              ctrl_bubble_o,
    output logic              pipe_hold_o,
    output logic [1:0]        hazard_type_o,
    output logic [STAT_W-1:0] stall_count_o
);

    localparam logic       MULTI_LU = (LOAD_USE_CYCLES > 1);
    localparam logic       BR_EN    = (BRANCH_IN_ID != 0);
    localparam logic [2:0] LU_RELOAD = 3'(LOAD_USE_CYCLES - 1);

    hz_state_e state_r, state_nxt_s;
    logic [2:0] lu_cnt_r, lu_cnt_nxt_s;

    logic [MAX_REG_AW-1:0] rs_ext_s, rt_ext_s, ex_rd_ext_s, mem_rd_ext_s;
    logic ex_match_s, mem_match_s, lu_hit_s, br_hit_s;

    assign rs_ext_s     = MAX_REG_AW'(ifid_rs_i);
    assign rt_ext_s     = MAX_REG_AW'(ifid_rt_i);
    assign ex_rd_ext_s  = MAX_REG_AW'(idex_rd_i);
    assign mem_rd_ext_s = MAX_REG_AW'(exmem_rd_i);

    assign ex_match_s  = reg_match(ifid_use_rs_i, rs_ext_s, ex_rd_ext_s)
                       | reg_match(ifid_use_rt_i, rt_ext_s, ex_rd_ext_s);
    assign mem_match_s = reg_match(ifid_use_rs_i, rs_ext_s, mem_rd_ext_s)
                       | reg_match(ifid_use_rt_i, rt_ext_s, mem_rd_ext_s);

    assign lu_hit_s = idex_mem_read_i & idex_reg_write_i & ex_match_s;
    assign br_hit_s = BR_EN & ifid_branch_i &
                      ((idex_reg_write_i & ex_match_s) | (exmem_mem_read_i & mem_match_s));

    // State register for the load-use stall sequencer
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r  <= IDLE;
            lu_cnt_r <= 3'd0;
        end else begin
            state_r  <= state_nxt_s;
            lu_cnt_r <= lu_cnt_nxt_s;
        end
    end

    // Next-state logic: a cache freeze holds everything; otherwise count down
    always_comb begin
        state_nxt_s  = state_r;
        lu_cnt_nxt_s = lu_cnt_r;
        if (dmem_stall_i) begin
            state_nxt_s  = state_r;
            lu_cnt_nxt_s = lu_cnt_r;
        end else begin
            case (state_r)
                LU_STALL: begin
                    if (lu_cnt_r <= 3'd1) begin
                        state_nxt_s  = IDLE;
                        lu_cnt_nxt_s = 3'd0;
                    end else begin
                        state_nxt_s  = LU_STALL;
                        lu_cnt_nxt_s = lu_cnt_r - 3'd1;
                    end
                end
                IDLE: begin
                    if (lu_hit_s && MULTI_LU) begin
                        state_nxt_s  = LU_STALL;
                        lu_cnt_nxt_s = LU_RELOAD;
                    end else begin
                        state_nxt_s  = IDLE;
                        lu_cnt_nxt_s = lu_cnt_r;
                    end
                end
                default: begin
                    state_nxt_s  = IDLE;
                    lu_cnt_nxt_s = 3'd0;
                end
            endcase
        end
    end

    // Output decode by priority; reset forces the safe stalled pattern at once
    always_comb begin
        pc_write_o    = 1'b1;
        ifid_write_o  = 1'b1;
        ctrl_bubble_o = 1'b0;
        pipe_hold_o   = 1'b0;
        hazard_type_o = HZ_NONE;
        if (!rst_i) begin
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            ctrl_bubble_o = 1'b1;
            pipe_hold_o   = 1'b0;
            hazard_type_o = HZ_NONE;
        end else if (dmem_stall_i) begin
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            ctrl_bubble_o = 1'b0;
            pipe_hold_o   = 1'b1;
            hazard_type_o = HZ_MEMFRZ;
        end else if ((state_r == LU_STALL) || lu_hit_s) begin
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            ctrl_bubble_o = 1'b1;
            pipe_hold_o   = 1'b0;
            hazard_type_o = HZ_LOADUSE;
        end else if (br_hit_s) begin
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            ctrl_bubble_o = 1'b1;
            pipe_hold_o   = 1'b0;
            hazard_type_o = HZ_BRANCH;
        end else begin
            pc_write_o    = 1'b1;
            ifid_write_o  = 1'b1;
            ctrl_bubble_o = 1'b0;
            pipe_hold_o   = 1'b0;
            hazard_type_o = HZ_NONE;
        end
    end

    sat_counter #(.W(STAT_W)) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (~pc_write_o),
        .cnt_o (stall_count_o)
    );

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Scoreboard bench: three configurations driven in lockstep, checked against
// a stall-budget reference model.
module tb_hazard_ctrl_unit;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       use_rs;
        logic       use_rt;
        logic       br;
        logic       ex_mr;
        logic       ex_rw;
        logic [4:0] ex_rd;
        logic       mem_mr;
        logic [4:0] mem_rd;
        logic       dmem;
    } stim_t;

    typedef struct packed {
        logic        pc;
        logic        ifid;
        logic        bub;
        logic        hold;
        logic [1:0]  ty;
        logic [15:0] cnt;
    } obs_t;

    typedef struct packed {
        obs_t [2:0] d;
    } trio_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [4:0] rs, rt, ex_rd, mem_rd;
    logic       use_rs, use_rt, br, ex_mr, ex_rw, mem_mr, dmem;

    logic        pc_w [3];
    logic        ifid_w [3];
    logic        bub [3];
    logic        hold [3];
    logic [1:0]  ty [3];
    logic [15:0] sc_a, sc_b;
    logic [2:0]  sc_c;

    // Configuration of each instance, mirrored by the reference model
    int luc_p [3]  = '{1, 3, 2};
    bit br_p [3]   = '{1'b1, 1'b1, 1'b0};
    int satmax [3] = '{65535, 65535, 7};

    int lu_left [3];
    int cnt_m [3];
    int checks = 0;
    int errors = 0;

    trio_t exp_q [$];
    trio_t mon_t;
    obs_t  mon_a;

    hazard_ctrl_unit #(.REG_AW(5), .LOAD_USE_CYCLES(1), .BRANCH_IN_ID(1), .STAT_W(16)) dut_a (
        .clk_i(clk), .rst_i(rst_n), .ifid_rs_i(rs), .ifid_rt_i(rt),
        .ifid_use_rs_i(use_rs), .ifid_use_rt_i(use_rt), .ifid_branch_i(br),
        .idex_mem_read_i(ex_mr), .idex_reg_write_i(ex_rw), .idex_rd_i(ex_rd),
        .exmem_mem_read_i(mem_mr), .exmem_rd_i(mem_rd), .dmem_stall_i(dmem),
        .pc_write_o(pc_w[0]), .ifid_write_o(ifid_w[0]), .ctrl_bubble_o(bub[0]),
        .pipe_hold_o(hold[0]), .hazard_type_o(ty[0]), .stall_count_o(sc_a));

    hazard_ctrl_unit #(.REG_AW(5), .LOAD_USE_CYCLES(3), .BRANCH_IN_ID(1), .STAT_W(16)) dut_b (
        .clk_i(clk), .rst_i(rst_n), .ifid_rs_i(rs), .ifid_rt_i(rt),
        .ifid_use_rs_i(use_rs), .ifid_use_rt_i(use_rt), .ifid_branch_i(br),
        .idex_mem_read_i(ex_mr), .idex_reg_write_i(ex_rw), .idex_rd_i(ex_rd),
        .exmem_mem_read_i(mem_mr), .exmem_rd_i(mem_rd), .dmem_stall_i(dmem),
        .pc_write_o(pc_w[1]), .ifid_write_o(ifid_w[1]), .ctrl_bubble_o(bub[1]),
        .pipe_hold_o(hold[1]), .hazard_type_o(ty[1]), .stall_count_o(sc_b));

    hazard_ctrl_unit #(.REG_AW(5), .LOAD_USE_CYCLES(2), .BRANCH_IN_ID(0), .STAT_W(3)) dut_c (
        .clk_i(clk), .rst_i(rst_n), .ifid_rs_i(rs), .ifid_rt_i(rt),
        .ifid_use_rs_i(use_rs), .ifid_use_rt_i(use_rt), .ifid_branch_i(br),
        .idex_mem_read_i(ex_mr), .idex_reg_write_i(ex_rw), .idex_rd_i(ex_rd),
        .exmem_mem_read_i(mem_mr), .exmem_rd_i(mem_rd), .dmem_stall_i(dmem),
        .pc_write_o(pc_w[2]), .ifid_write_o(ifid_w[2]), .ctrl_bubble_o(bub[2]),
        .pipe_hold_o(hold[2]), .hazard_type_o(ty[2]), .stall_count_o(sc_c));

    function automatic obs_t get_obs(input int k);
        obs_t o;
        o.pc   = pc_w[k];
        o.ifid = ifid_w[k];
        o.bub  = bub[k];
        o.hold = hold[k];
        o.ty   = ty[k];
        case (k)
            0:       o.cnt = sc_a;
            1:       o.cnt = sc_b;
            default: o.cnt = 16'(sc_c);
        endcase
        return o;
    endfunction

    function automatic bit dep(input bit u, input logic [4:0] s, input logic [4:0] d);
        return u && (s == d) && (d != 5'd0);
    endfunction

    // Reference: each load-use hazard buys a fixed budget of stall cycles,
    // a freeze pauses that budget, and stall cycles are tallied with a cap.
    task automatic model_step(input int k, input stim_t s, input bit rl, output obs_t o);
        bit on_ex, on_mem, lu, brh;
        on_ex  = dep(s.use_rs, s.rs, s.ex_rd) || dep(s.use_rt, s.rt, s.ex_rd);
        on_mem = dep(s.use_rs, s.rs, s.mem_rd) || dep(s.use_rt, s.rt, s.mem_rd);
        lu  = s.ex_mr && s.ex_rw && on_ex;
        brh = br_p[k] && s.br && ((s.ex_rw && on_ex) || (s.mem_mr && on_mem));
        if (rl) begin
            lu_left[k] = 0;
            cnt_m[k]   = 0;
            o = {1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 16'd0};
            return;
        end
        o.cnt = 16'(cnt_m[k]);
        if (s.dmem) begin
            {o.pc, o.ifid, o.bub, o.hold, o.ty} = {1'b0, 1'b0, 1'b0, 1'b1, 2'd3};
        end else if (lu_left[k] > 0) begin
            {o.pc, o.ifid, o.bub, o.hold, o.ty} = {1'b0, 1'b0, 1'b1, 1'b0, 2'd1};
            lu_left[k] = lu_left[k] - 1;
        end else if (lu) begin
            {o.pc, o.ifid, o.bub, o.hold, o.ty} = {1'b0, 1'b0, 1'b1, 1'b0, 2'd1};
            lu_left[k] = luc_p[k] - 1;
        end else if (brh) begin
            {o.pc, o.ifid, o.bub, o.hold, o.ty} = {1'b0, 1'b0, 1'b1, 1'b0, 2'd2};
        end else begin
            {o.pc, o.ifid, o.bub, o.hold, o.ty} = {1'b1, 1'b1, 1'b0, 1'b0, 2'd0};
        end
        if (!o.pc && cnt_m[k] < satmax[k]) cnt_m[k] = cnt_m[k] + 1;
    endtask

    // Apply one cycle of stimulus and enqueue the expected response
    task automatic drive(input stim_t s, input bit rl);
        trio_t t;
        obs_t  o;
        @(posedge clk);
        #1;
        rs = s.rs; rt = s.rt; use_rs = s.use_rs; use_rt = s.use_rt; br = s.br;
        ex_mr = s.ex_mr; ex_rw = s.ex_rw; ex_rd = s.ex_rd;
        mem_mr = s.mem_mr; mem_rd = s.mem_rd; dmem = s.dmem;
        rst_n = ~rl;
        for (int k = 0; k < 3; k++) begin
            model_step(k, s, rl, o);
            t.d[k] = o;
        end
        exp_q.push_back(t);
    endtask

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: actual %0d, expected %0d", name, got, want);
        end
    endtask

    // Monitor: outputs are combinational, so each cycle presents a response
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_t = exp_q.pop_front();
            for (int k = 0; k < 3; k++) begin
                mon_a = get_obs(k);
                checks++;
                if (mon_a !== mon_t.d[k]) begin
                    errors++;
                    $display("FAIL dut%0d outputs at %0t: actual pc=%b ifid=%b bub=%b hold=%b type=%0d cnt=%0d, expected pc=%b ifid=%b bub=%b hold=%b type=%0d cnt=%0d",
                             k, $time, mon_a.pc, mon_a.ifid, mon_a.bub, mon_a.hold, mon_a.ty, mon_a.cnt,
                             mon_t.d[k].pc, mon_t.d[k].ifid, mon_t.d[k].bub, mon_t.d[k].hold,
                             mon_t.d[k].ty, mon_t.d[k].cnt);
                end
            end
        end
    end

    initial begin
        stim_t idle, lw2, lw0, br_alu, br_ld, frz, r;
        idle = '0;
        lw2 = '0; lw2.rs = 5'd2; lw2.use_rs = 1'b1; lw2.ex_mr = 1'b1; lw2.ex_rw = 1'b1; lw2.ex_rd = 5'd2;
        lw0 = '0; lw0.rs = 5'd0; lw0.use_rs = 1'b1; lw0.ex_mr = 1'b1; lw0.ex_rw = 1'b1; lw0.ex_rd = 5'd0;
        br_alu = '0; br_alu.br = 1'b1; br_alu.rs = 5'd5; br_alu.use_rs = 1'b1; br_alu.ex_rw = 1'b1; br_alu.ex_rd = 5'd5;
        br_ld = '0; br_ld.br = 1'b1; br_ld.rs = 5'd5; br_ld.use_rs = 1'b1; br_ld.mem_mr = 1'b1; br_ld.mem_rd = 5'd5;
        frz = '0; frz.dmem = 1'b1;

        rst_n = 1'b0;
        {rs, rt, ex_rd, mem_rd} = '0;
        {use_rs, use_rt, br, ex_mr, ex_rw, mem_mr, dmem} = '0;
        for (int k = 0; k < 3; k++) begin lu_left[k] = 0; cnt_m[k] = 0; end

        // Reset, then a single load-use hazard followed by idle cycles
        drive(idle, 1'b1);
        drive(idle, 1'b1);
        drive(lw2, 1'b0);
        for (int i = 0; i < 4; i++) drive(idle, 1'b0);
        @(negedge clk);
        chk("lu_stalls_c1", sc_a, 1);
        chk("lu_stalls_c3", sc_b, 3);
        chk("lu_stalls_c2", sc_c, 2);

        // Zero destination register, then branch operand hazards
        drive(lw0, 1'b0);
        drive(idle, 1'b0);
        drive(br_alu, 1'b0);
        drive(idle, 1'b0);
        drive(br_ld, 1'b0);
        drive(idle, 1'b0);

        // Freeze for 4 cycles in the middle of a 3-cycle load-use stall
        drive(idle, 1'b1);
        drive(lw2, 1'b0);
        for (int i = 0; i < 4; i++) drive(frz, 1'b0);
        for (int i = 0; i < 4; i++) drive(idle, 1'b0);
        @(negedge clk);
        chk("freeze_total_c3", sc_b, 7);

        // Reset during the load-use stall aborts it
        drive(lw2, 1'b0);
        drive(idle, 1'b1);
        @(negedge clk);
        chk("rst_pc_write", int'(pc_w[1]), 0);
        chk("rst_count", sc_b, 0);
        drive(idle, 1'b0);
        @(negedge clk);
        chk("post_rst_no_stall", int'(pc_w[1]), 1);

        // Randomized traffic with a narrow register range to provoke matches
        for (int i = 0; i < 3000; i++) begin
            r.rs     = 5'($urandom_range(0, 3));
            r.rt     = 5'($urandom_range(0, 3));
            r.use_rs = 1'($urandom_range(0, 1));
            r.use_rt = 1'($urandom_range(0, 1));
            r.br     = 1'($urandom_range(0, 1));
            r.ex_mr  = 1'($urandom_range(0, 1));
            r.ex_rw  = 1'($urandom_range(0, 1));
            r.ex_rd  = 5'($urandom_range(0, 3));
            r.mem_mr = 1'($urandom_range(0, 1));
            r.mem_rd = 5'($urandom_range(0, 3));
            r.dmem   = ($urandom_range(0, 9) == 0);
            drive(r, $urandom_range(0, 199) == 0);
        end
        drive(idle, 1'b0);
        @(negedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
